// File: rtl/bk16_mp_add_sched_pkg.sv
// bk_sched_pkg: shared types, constants and rotating-priority search for the shared-adder scheduler
package bk_sched_pkg;
  localparam int LIMB_W = 16;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  function automatic int rr_pick(input logic [7:0] req, input int n, input int ptr);
    int r;
    r = 0;
    for (int k = n - 1; k >= 0; k--)
      if (req[3'((ptr + k) % n)]) r = (ptr + k) % n;
    return r;
  endfunction
endpackage

// File: rtl/bk16.sv
// bk16: 16-bit Brent-Kung prefix adder with carry-in
module bk16 (
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic        p_out,
  output logic        g_out
);
  logic [15:0] p, g, pp, gg;
  logic [16:0] c;
  assign p = x1 ^ x2;
  assign g = x1 & x2;
  // Up-sweep builds power-of-two group terms, down-sweep fills in the remaining prefixes
  always_comb begin
    gg = g;
    pp = p;
    gg[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < 16; d = d * 2)
      for (int i = 0; i < 16; i++)
        if ((i + 1) % (2 * d) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i - d]);
          pp[i] = pp[i] & pp[i - d];
        end
    for (int d = 4; d >= 1; d = d / 2)
      for (int i = 2 * d; i < 16; i++)
        if ((i + 1) % (2 * d) == d) begin
          gg[i] = gg[i] | (pp[i] & gg[i - d]);
          pp[i] = pp[i] & pp[i - d];
        end
  end
  assign c = {gg, cin};
  assign s = p ^ c[15:0];
  assign cout = c[16];
  assign p_out = &p;
  assign g_out = gg[15];
endmodule

// File: rtl/bk16_mp_add_sched_rr_arb.sv
// rr_arb: combinational round-robin pick of the first request at or after ptr
module rr_arb
  import bk_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  grant,
  output logic            any_req
);
  assign any_req = |req;
  assign grant = IDW'(rr_pick(8'(req), NREQ, int'(ptr)));
endmodule

// File: rtl/bk16_mp_add_sched.sv
// bk16_mp_add_sched: round-robin sharing of one bk16 among requesters streaming multi-limb adds
module bk16_mp_add_sched
  import bk_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAXLIMB = 8,
  parameter int IDW     = $clog2(NREQ),
  parameter int LW      = $clog2(MAXLIMB)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [LIMB_W*NREQ-1:0] req_a,
  input  logic [LIMB_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]        req_cin,
  input  logic [NREQ-1:0]        req_last,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [LIMB_W-1:0]      res_sum,
  output logic                   res_cout,
  output logic                   res_last,
  output logic                   res_err,
  output logic [IDW-1:0]         res_id,
  output logic [LW-1:0]          res_idx
);
  state_t state;
  logic [IDW-1:0] rr_ptr, owner, gnt;
  logic [LW-1:0] idx_q;
  logic [LIMB_W-1:0] x1, x2, s;
  logic any_req, carry_q, cin, cout, can_take, beat, at_max, fin;
  assign can_take = !res_valid || res_ready;
  assign beat = (state == BUSY) && req_valid[owner] && can_take;
  assign req_ready = (state == BUSY && can_take) ? NREQ'(1) << owner : '0;
  assign x1 = req_a[owner*LIMB_W +: LIMB_W];
  assign x2 = req_b[owner*LIMB_W +: LIMB_W];
  assign cin = (idx_q == '0) ? req_cin[owner] : carry_q;
  assign at_max = idx_q == LW'(MAXLIMB - 1);
  assign fin = req_last[owner] || at_max;
  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .grant(gnt), .any_req(any_req)
  );
  bk16 u_add (
    .x1(x1), .x2(x2), .cin(cin), .s(s), .cout(cout), .p_out(), .g_out()
  );
  // Grant/ownership FSM with limb index and inter-limb carry chaining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      carry_q <= 1'b0;
      idx_q <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        owner <= gnt;
        rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        idx_q <= '0;
        carry_q <= req_cin[gnt];
        state <= BUSY;
      end
    end else if (beat) begin
      carry_q <= cout;
      idx_q <= idx_q + 1'b1;
      if (fin) state <= IDLE;
    end
  end
  // Result register: load on accepted beat, drop valid after a handshake with no new beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum <= '0;
      res_cout <= 1'b0;
      res_last <= 1'b0;
      res_err <= 1'b0;
      res_id <= '0;
      res_idx <= '0;
    end else if (beat) begin
      res_valid <= 1'b1;
      res_sum <= s;
      res_cout <= cout;
      res_last <= fin;
      res_err <= at_max && !req_last[owner];
      res_id <= owner;
      res_idx <= idx_q;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: doc/bk16_mp_add_sched.md
Name: bk16_mp_add_sched

Overview:
- Shares one 16-bit prefix adder (a bk16 instance) among NREQ requesters.
- Each requester submits a multi-precision add as a stream of 16-bit limbs, least-significant limb first.
- The block arbitrates round-robin and holds the grant for the whole transaction. It chains carry between limbs and returns one registered sum limb per accepted beat.
- It sits between client datapaths and the shared adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAXLIMB, 8, maximum limbs per transaction. Power of two, at least 2.
- IDW, $clog2(NREQ), width of the requester id.
- LW, $clog2(MAXLIMB), width of the limb index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_ready  out  NREQ  per-requester beat accept.
- req_a  in  16*NREQ  operand-A limb; requester i uses bits [16i+15:16i].
- req_b  in  16*NREQ  operand-B limb, same packing.
- req_cin  in  NREQ  transaction carry-in; sampled on the first limb only.
- req_last  in  NREQ  marks the final limb of the transaction.
- res_valid  out  1  result beat valid.
- res_ready  in  1  result beat accept.
- res_sum  out  16  sum limb.
- res_cout  out  1  carry out of this limb.
- res_last  out  1  final limb of the transaction.
- res_err  out  1  transaction truncated at MAXLIMB.
- res_id  out  IDW  owning requester.
- res_idx  out  LW  limb index, 0-based.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, owner=0, carry_q=0, idx_q=0.
  - res_valid=0, and res_sum/res_cout/res_last/res_err/res_id/res_idx all 0.
  - req_ready=0.
  - Asserting reset mid-transaction abandons it; no partial result is emitted after release.
- States: IDLE, BUSY.
- IDLE:
  - req_ready=0.
  - If any req_valid is set, grant the first set bit at or after rr_ptr, searching upward with wrap-around.
  - On grant: owner<=granted, rr_ptr<=granted+1 (mod NREQ), idx_q<=0, carry_q<=req_cin[granted], state<=BUSY.
  - The grant cycle accepts no data.
- BUSY:
  - req_ready[i] = (i==owner) && (!res_valid || res_ready). All other bits are 0.
  - Beat accepted when req_valid[owner] && req_ready[owner].
  - Adder inputs: x1=req_a[owner], x2=req_b[owner]. cin = (idx_q==0) ? req_cin[owner] : carry_q.
  - On an accepted beat, the next edge loads the output register:
    - res_sum=s, res_cout=cout, res_id=owner, res_idx=idx_q.
    - res_last = req_last[owner] || (idx_q==MAXLIMB-1).
    - res_err = (idx_q==MAXLIMB-1) && !req_last[owner].
    - res_valid=1.
  - Same edge: carry_q<=cout, idx_q<=idx_q+1. If res_last is set, state<=IDLE.
- Latency and throughput:
  - One cycle from accepted beat to res_valid.
  - One limb per cycle sustained while res_ready=1.
  - One dead (grant) cycle between transactions.
- Owner stall: if req_valid[owner] deasserts mid-transaction, the block waits in BUSY. The grant, carry_q and idx_q are held, and no other requester is served.
- Output backpressure:
  - res_valid=1 and res_ready=0 holds every res_* output stable and deasserts req_ready.
  - res_valid falls only after a res_ready handshake with no new beat accepted in that cycle.
  - Consume and accept in the same cycle is allowed (full throughput).
- Truncation: at MAXLIMB beats without req_last, the block forces the end of the transaction and flags res_err. Any remaining requester beats are then treated as a new transaction.
- Values on req_a/req_b/req_last of non-owners are ignored.

Decomposition:
- Shared package bk_sched_pkg:
  - state enum {IDLE, BUSY}.
  - Constant LIMB_W=16.
  - Function for the rotating priority search.
- Sub-module rr_arb:
  - Inputs: NREQ-bit request vector and rr_ptr.
  - Outputs: one-hot/encoded grant and any_req.
  - Purely combinational; the pointer register stays in the parent.
- The adder is instantiated directly as bk16 (x1, x2, cin, s, cout). p_out and g_out are left unconnected.

Test Plan:
1. Single-limb, req0: a=0xFFFF, b=0x0001, cin=0, last=1 → grant cycle, then next cycle res_sum=0x0000, res_cout=1, res_last=1, res_id=0, res_idx=0.
2. Three-limb carry chain, req2, limbs (0xFFFF,0x0001), (0xFFFF,0x0000), (0x1234,0x0000), cin=0 → sums 0x0000, 0x0000, 0x1235. Couts 1, 1, 0. Indices 0, 1, 2. Last set only on index 2.
3. Round-robin: all four requesters hold 1-limb transactions from reset → service order 0,1,2,3. After completion, req1 and req3 re-request → order 1 then 3 (rr_ptr=0 after serving 3 → search 0,1,…).
4. Backpressure: res_ready=0 for 5 cycles during a 4-limb stream → outputs frozen, req_ready=0. Releasing res_ready resumes at 1 limb/cycle with correct carry.
5. Truncation: MAXLIMB=8, 9 beats with no last → 8th beat has res_last=1 and res_err=1. The 9th beat starts a new transaction using req_cin.
6. Reset mid-transaction after limb 1 of 3 → all outputs 0 during reset. After release, state=IDLE and a new request is granted from rr_ptr=0.
